audio_frame_cacher: RTL and testbench
=====================================

# audio_frame_cacher

Write side of the waveform dual-port RAM that the spectrum pipeline reads through `DPRAMAddr`/`RAM_Q`. It accepts stereo sample strobes from the audio receiver and writes one frame of 2^bw_fftp L/R sample pairs into the DPRAM, with L in the lower half and R in the upper half. When the frame is complete it raises `StartLoader` to the FFT loader. It then freezes the buffer until the consumer reports the frame has been read.

## Interface
Parameters:
- `bw_fftp`, 11, log2 of samples per channel per frame.
- `bw_dpram`, 12, DPRAM address width; must equal bw_fftp+1.
- `bw_data`, 16, sample width, two's complement, passed through unmodified.

Ports:
- `Clock`  in  1  single system clock; all logic on its rising edge.
- `Reset`  in  1  synchronous, active-high.
- `Enable`  in  1  capture enable; low forces IDLE.
- `SampleEn`  in  1  one-cycle strobe; `DataL`/`DataR` are valid in the same cycle.
- `DataL`  in  bw_data  left sample.
- `DataR`  in  bw_data  right sample.
- `Consumed`  in  1  one-cycle pulse from the downstream reader: frame fully read, buffer may be refilled.
- `RAM_WAddr`  out  bw_dpram  DPRAM write address.
- `RAM_D`  out  bw_data  DPRAM write data.
- `RAM_WE`  out  1  DPRAM write enable.
- `StartLoader`  out  1  one-cycle pulse: frame ready.
- `Full`  out  1  high while a frame is held for reading.
- `Overrun`  out  1  sticky; set by a strobe-spacing violation.
- `Level`  out  bw_fftp  number of pairs written in the current frame.

## Operation
- States: IDLE, FILL, FULL.
  - IDLE: idx=0, no writes. Goes to FILL on the cycle after `Enable`=1.
  - FILL: accepts samples.
  - FULL: `Full`=1. All strobes are dropped silently; this is normal frame snapshotting and is not an overrun.
- Accepted strobe (FILL, write engine idle):
  - Latch `DataL` and `DataR`.
  - Next cycle: write L at address {1'b0, idx}.
  - Following cycle: write R at address {1'b1, idx}, then idx = idx+1.
- Write engine busy: a strobe arriving while either pending write is outstanding is dropped and sets `Overrun`.
- Frame end:
  - After the R write at idx = 2^bw_fftp - 1, go to FULL, pulse `StartLoader` and reset idx to 0.
  - `Level` wraps to 0 at the same point.
- FULL to FILL on `Consumed`=1.
  - A strobe in the same cycle as `Consumed` is dropped; the transition takes effect on the next cycle.
  - `Consumed` is ignored in IDLE and FILL.
- `Enable`=0 in any state:
  - next state is IDLE, idx=0, `Full`=0;
  - any pending write is discarded: `RAM_WE` stays low and the partial pair is never written.
- `Overrun` clears only on `Reset`.
- `Level` = idx; it is 0 in IDLE and 0 in FULL.

## Timing
- Reset values: `RAM_WE`=0, `RAM_WAddr`=0, `RAM_D`=0, `StartLoader`=0, `Full`=0, `Overrun`=0, `Level`=0. State is IDLE.
- `Reset` mid-frame aborts with no further writes.
- All outputs are registered.
- Strobe at cycle T, accepted:
  - T+1: `RAM_WE`=1, `RAM_WAddr`={0,idx}, `RAM_D`=L.
  - T+2: `RAM_WE`=1, `RAM_WAddr`={1,idx}, `RAM_D`=R.
  - T+3: `Level` = idx+1.
- Minimum strobe spacing is 3 cycles.
  - Strobes at T+1 or T+2 are dropped, and `Overrun`=1 from the following cycle.
  - A strobe at T+3 is accepted normally.
- Last pair of a frame (strobe at T):
  - `StartLoader`=1 at T+3 only.
  - `Full`=1 from T+3 onward.
- `Consumed` at cycle C:
  - C+1: `Full`=0.
  - The first strobe accepted is at C+1 or later; it writes idx 0.
- `Enable` fall at cycle E: no `RAM_WE` from E+1 onward.
- `RAM_WE` is never high on two consecutive cycles for the same channel.
- `RAM_WE` is low in IDLE and FULL.

## Test plan
1. Fill one frame (bw_fftp=3, bw_dpram=4, Enable=1). Stimulus: 8 strobes spaced 4 cycles, L=0x1000+i, R=0x2000+i. Required:
   - writes alternate, addr 0..7 with L values and addr 8..15 with R values;
   - `StartLoader` pulses exactly once, 3 cycles after the 8th strobe;
   - `Full`=1 afterwards, `Overrun`=0.
2. Frame held. Stimulus: 5 strobes in FULL, then `Consumed`, then one strobe with L=0x7FFF, R=0x8000. Required:
   - no writes while FULL;
   - after `Consumed`, 0x7FFF is written at addr 0 and 0x8000 at addr 8;
   - `Level`=1 afterwards.
3. Spacing violation. Stimulus: strobes at T, T+2 and T+3. Required:
   - the T+2 strobe is dropped and `Overrun`=1 from T+3;
   - the T+3 strobe writes idx 1;
   - `Overrun` stays 1 through later accepted strobes.
4. Simultaneous `Consumed` and strobe in FULL. Required:
   - that strobe is not written;
   - a strobe 1 cycle later is written at addr 0/8.
5. Mid-frame `Enable` drop. Stimulus: after 3 pairs, strobe at T, `Enable`=0 at T+1. Required:
   - L is written at T+1 and the R write at T+2 is suppressed;
   - `Level`=0;
   - after re-enable, the next strobe writes addr 0.
6. Reset mid-frame. Stimulus: assert `Reset` at the cycle after a strobe. Required:
   - all outputs 0 on the next cycle, no `RAM_WE`, state IDLE;
   - `Overrun`, if previously set, clears.

Source files
------------

// File: rtl/audio_frame_cacher_if.sv
// Signal bundle between the frame cacher, the audio receiver, the DPRAM write
// port and the FFT loader.
interface audio_frame_cacher_if #(
   parameter int bw_fftp  = 11,
   parameter int bw_dpram = 12,
   parameter int bw_data  = 16
);

   logic                Enable;
   logic                SampleEn;
   logic [bw_data-1:0]  DataL;
   logic [bw_data-1:0]  DataR;
   logic                Consumed;
   logic [bw_dpram-1:0] RAM_WAddr;
   logic [bw_data-1:0]  RAM_D;
   logic                RAM_WE;
   logic                StartLoader;
   logic                Full;
   logic                Overrun;
   logic [bw_fftp-1:0]  Level;

   modport master (
      input  Enable, SampleEn, DataL, DataR, Consumed,
      output RAM_WAddr, RAM_D, RAM_WE, StartLoader, Full, Overrun, Level
   );

   modport slave (
      output Enable, SampleEn, DataL, DataR, Consumed,
      input  RAM_WAddr, RAM_D, RAM_WE, StartLoader, Full, Overrun, Level
   );

endinterface

// File: rtl/audio_frame_cacher.sv
// Write side of the spectrum waveform DPRAM: captures one frame of stereo pairs
// (L in the lower half, R in the upper half) and freezes it until consumed.
module audio_frame_cacher #(
   parameter int bw_fftp  = 11,
   parameter int bw_dpram = 12,
   parameter int bw_data  = 16
) (
   input  logic                 Clock,
   input  logic                 Reset,
   audio_frame_cacher_if.master bus
);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_FULL} state_t;
   typedef enum logic [1:0] {WR_IDLE, WR_LEFT, WR_RIGHT} wr_phase_t;

   localparam logic [bw_fftp-1:0] idx_one = 1;

   state_t              state, state_nx;
   wr_phase_t           phase, phase_nx;
   logic [bw_fftp-1:0]  idx, idx_nx;
   logic [bw_data-1:0]  hold_r, hold_r_nx;

   logic                ram_we, ram_we_nx;
   logic [bw_dpram-1:0] ram_waddr, ram_waddr_nx;
   logic [bw_data-1:0]  ram_d, ram_d_nx;
   logic                start_loader, start_nx;
   logic                full, full_nx;
   logic                overrun, overrun_nx;

   logic                filling;
   logic                accept;
   logic                collide;
   logic                frame_end;

   // A strobe is taken only when both writes of the previous pair are done.
   assign filling   = bus.Enable && (state == S_FILL);
   assign accept    = filling && bus.SampleEn && (phase == WR_IDLE);
   assign collide   = filling && bus.SampleEn && (phase != WR_IDLE);
   assign frame_end = filling && (phase == WR_RIGHT) && (idx == '1);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state        <= S_IDLE;
         phase        <= WR_IDLE;
         idx          <= '0;
         hold_r       <= '0;
         ram_we       <= 1'b0;
         ram_waddr    <= '0;
         ram_d        <= '0;
         start_loader <= 1'b0;
         full         <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         state        <= state_nx;
         phase        <= phase_nx;
         idx          <= idx_nx;
         hold_r       <= hold_r_nx;
         ram_we       <= ram_we_nx;
         ram_waddr    <= ram_waddr_nx;
         ram_d        <= ram_d_nx;
         start_loader <= start_nx;
         full         <= full_nx;
         overrun      <= overrun_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      phase_nx  = phase;
      idx_nx    = idx;
      hold_r_nx = hold_r;
      if (!bus.Enable) begin
         // Dropping Enable abandons any half-written pair.
         state_nx = S_IDLE;
         phase_nx = WR_IDLE;
         idx_nx   = '0;
      end else begin
         unique case (state)
            S_IDLE:  state_nx = S_FILL;
            S_FILL:  if (frame_end) state_nx = S_FULL;
            S_FULL:  if (bus.Consumed) state_nx = S_FILL;
            default: state_nx = S_IDLE;
         endcase
         unique case (phase)
            WR_IDLE:  if (accept) phase_nx = WR_LEFT;
            WR_LEFT:  phase_nx = WR_RIGHT;
            WR_RIGHT: begin
               phase_nx = WR_IDLE;
               idx_nx   = idx + idx_one;
            end
            default:  phase_nx = WR_IDLE;
         endcase
         if (accept) hold_r_nx = bus.DataR;
      end
   end

   always_comb begin
      ram_we_nx    = 1'b0;
      ram_waddr_nx = ram_waddr;
      ram_d_nx     = ram_d;
      if (accept) begin
         ram_we_nx    = 1'b1;
         ram_waddr_nx = {1'b0, idx};
         ram_d_nx     = bus.DataL;
      end else if (bus.Enable && (phase == WR_LEFT)) begin
         ram_we_nx    = 1'b1;
         ram_waddr_nx = {1'b1, idx};
         ram_d_nx     = hold_r;
      end
      start_nx   = frame_end;
      full_nx    = (state_nx == S_FULL);
      overrun_nx = overrun | collide;
   end

   assign bus.RAM_WE      = ram_we;
   assign bus.RAM_WAddr   = ram_waddr;
   assign bus.RAM_D       = ram_d;
   assign bus.StartLoader = start_loader;
   assign bus.Full        = full;
   assign bus.Overrun     = overrun;
   assign bus.Level       = idx;

endmodule

// File: tb/tb_audio_frame_cacher.sv
// Self-checking bench for audio_frame_cacher against an event-scheduled
// reference model of frame capture.
`timescale 1ns/1ps
module tb_audio_frame_cacher;

   localparam int BF    = 3;
   localparam int BD    = 4;
   localparam int BW    = 16;
   localparam int NPAIR = 1 << BF;

   logic Clock = 1'b0;
   logic Reset = 1'b1;
   always #5 Clock = ~Clock;

   audio_frame_cacher_if #(.bw_fftp(BF), .bw_dpram(BD), .bw_data(BW)) bus ();

   audio_frame_cacher #(.bw_fftp(BF), .bw_dpram(BD), .bw_data(BW)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      int              t;
      logic [BD-1:0]   a;
      logic [BW-1:0]   d;
   } wr_ev_t;

   // Model: 0 idle, 1 filling, 2 holding a full frame.
   wr_ev_t wq[$];
   int     m_state = 0;
   int     m_last  = -100;
   int     m_done  = -1;
   int     m_level = 0;
   bit     m_ovr   = 1'b0;
   bit     m_start = 1'b0;

   logic          e_we;
   logic [BD-1:0] e_addr;
   logic [BW-1:0] e_d;
   logic [BF+3:0] got_v, exp_v;
   logic [BW-1:0] obs [0:2*NPAIR-1];

   task automatic model_edge(input bit rst, input bit en, input bit se,
                             input logic [BW-1:0] l, input logic [BW-1:0] r, input bit cons);
      int prev;
      m_start = 1'b0;
      if (rst) begin
         wq.delete();
         m_state = 0; m_last = -100; m_done = -1; m_level = 0; m_ovr = 1'b0;
      end else if (!en) begin
         while (wq.size() > 0 && wq[$].t > cyc) void'(wq.pop_back());
         m_state = 0; m_last = -100; m_done = -1; m_level = 0;
      end else begin
         prev = m_state;
         if (m_done == cyc + 1) begin
            m_done = -1;
            m_level++;
            if (m_level == NPAIR) begin
               m_level = 0;
               m_start = 1'b1;
            end
         end
         if (prev == 1 && se) begin
            if (cyc - m_last >= 3) begin
               wq.push_back('{cyc + 1, BD'(m_level), l});
               wq.push_back('{cyc + 2, BD'(NPAIR + m_level), r});
               m_last = cyc;
               m_done = cyc + 3;
            end else begin
               m_ovr = 1'b1;
            end
         end
         case (prev)
            0:       m_state = 1;
            1:       if (m_start) m_state = 2;
            default: if (cons) m_state = 1;
         endcase
      end
      e_we = 1'b0; e_addr = '0; e_d = '0;
      while (wq.size() > 0 && wq[0].t <= cyc + 1) begin
         if (wq[0].t == cyc + 1) begin
            e_we = 1'b1; e_addr = wq[0].a; e_d = wq[0].d;
         end
         void'(wq.pop_front());
      end
   endtask

   task automatic tick(input bit rst, input bit en, input bit se,
                       input logic [BW-1:0] l, input logic [BW-1:0] r, input bit cons);
      @(negedge Clock);
      Reset = rst; bus.Enable = en; bus.SampleEn = se;
      bus.DataL = l; bus.DataR = r; bus.Consumed = cons;
      @(posedge Clock);
      model_edge(rst, en, se, l, r, cons);
      cyc++;
      #1;
      got_v = {bus.RAM_WE, bus.StartLoader, bus.Full, bus.Overrun, bus.Level};
      exp_v = {e_we, m_start, (m_state == 2), m_ovr, BF'(m_level)};
      if (bus.RAM_WE === 1'b1) obs[bus.RAM_WAddr] = bus.RAM_D;
   endtask

   task automatic clear_obs();
      for (int a = 0; a < 2*NPAIR; a++) obs[a] = 'x;
   endtask

   task automatic test_reset();
      for (int c = 0; c < 3; c++) begin
         tick(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
         checks++;
         if ({bus.RAM_WE, bus.RAM_WAddr, bus.RAM_D, bus.StartLoader, bus.Full, bus.Overrun, bus.Level} !== '0) begin
            errors++;
            $display("FAIL reset_outputs cyc=%0d got we=%b addr=%h d=%h st=%b full=%b ovr=%b lvl=%0d required all 0",
                     cyc, bus.RAM_WE, bus.RAM_WAddr, bus.RAM_D, bus.StartLoader, bus.Full, bus.Overrun, bus.Level);
         end
      end
   endtask

   task automatic test_fill_frame();
      int t_last = -1, starts = 0, start_cyc = -1, i;
      bit se;
      logic [BW-1:0] l, r, ev;
      clear_obs();
      for (int c = 0; c < 34; c++) begin
         i  = (c - 1) / 4;
         se = (c >= 1) && ((c - 1) % 4 == 0) && (i < NPAIR);
         l  = 16'h1000 + BW'(i);
         r  = 16'h2000 + BW'(i);
         tick(1'b0, 1'b1, se, l, r, 1'b0);
         if (se) t_last = cyc - 1;
         if (bus.StartLoader === 1'b1) begin starts++; start_cyc = cyc; end
         checks++;
         if (got_v !== exp_v) begin errors++; $display("FAIL fill_status cyc=%0d got=%b required=%b", cyc, got_v, exp_v); end
         if (e_we) begin
            checks++;
            if (bus.RAM_WAddr !== e_addr || bus.RAM_D !== e_d) begin
               errors++; $display("FAIL fill_write cyc=%0d got=%h/%h required=%h/%h", cyc, bus.RAM_WAddr, bus.RAM_D, e_addr, e_d);
            end
         end
      end
      for (int a = 0; a < 2*NPAIR; a++) begin
         ev = (a < NPAIR) ? 16'h1000 + BW'(a) : 16'h2000 + BW'(a - NPAIR);
         checks++;
         if (obs[a] !== ev) begin errors++; $display("FAIL frame_mem addr=%0d got=%h required=%h", a, obs[a], ev); end
      end
      checks++;
      if (starts != 1 || start_cyc != t_last + 3) begin
         errors++; $display("FAIL start_pulse got count=%0d at=%0d required count=1 at=%0d", starts, start_cyc, t_last + 3);
      end
      checks++;
      if (bus.Full !== 1'b1 || bus.Overrun !== 1'b0) begin
         errors++; $display("FAIL full_after_frame got full=%b ovr=%b required full=1 ovr=0", bus.Full, bus.Overrun);
      end
   endtask

   task automatic test_full_hold();
      int wes = 0;
      bit se, cons;
      logic [BW-1:0] l, r;
      clear_obs();
      for (int c = 0; c < 16; c++) begin
         se = (c < 10) && (c % 2 == 0);
         cons = (c == 10);
         l = BW'($urandom); r = BW'($urandom);
         if (c == 11) begin se = 1'b1; l = 16'h7FFF; r = 16'h8000; end
         tick(1'b0, 1'b1, se, l, r, cons);
         if (c <= 10 && bus.RAM_WE === 1'b1) wes++;
         checks++;
         if (got_v !== exp_v) begin errors++; $display("FAIL hold_status cyc=%0d got=%b required=%b", cyc, got_v, exp_v); end
         if (e_we) begin
            checks++;
            if (bus.RAM_WAddr !== e_addr || bus.RAM_D !== e_d) begin
               errors++; $display("FAIL hold_write cyc=%0d got=%h/%h required=%h/%h", cyc, bus.RAM_WAddr, bus.RAM_D, e_addr, e_d);
            end
         end
      end
      checks++;
      if (wes != 0) begin errors++; $display("FAIL writes_in_full got=%0d required=0", wes); end
      checks++;
      if (obs[0] !== 16'h7FFF || obs[NPAIR] !== 16'h8000) begin
         errors++; $display("FAIL refill_first got=%h/%h required=7fff/8000", obs[0], obs[NPAIR]);
      end
      checks++;
      if (bus.Level !== 3'd1) begin errors++; $display("FAIL refill_level got=%0d required=1", bus.Level); end
   endtask

   task automatic test_spacing();
      bit se;
      logic [BW-1:0] l, r, l3;
      logic [BD-1:0] ea;
      ea = BD'(m_level + 1);
      l3 = '0;
      for (int c = 0; c < 60; c++) begin
         se = (c == 0 || c == 2 || c == 3) || (c > 3 && c % 3 == 0 && m_state == 1);
         l = BW'($urandom); r = BW'($urandom);
         if (c == 3) l3 = l;
         tick(1'b0, 1'b1, se, l, r, 1'b0);
         if (c == 2) begin
            checks++;
            if (bus.Overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got=%b required=1", bus.Overrun); end
         end
         if (c == 3) begin
            checks++;
            if (bus.RAM_WE !== 1'b1 || bus.RAM_WAddr !== ea || bus.RAM_D !== l3) begin
               errors++; $display("FAIL spaced_accept got we=%b %h/%h required 1 %h/%h", bus.RAM_WE, bus.RAM_WAddr, bus.RAM_D, ea, l3);
            end
         end
         checks++;
         if (got_v !== exp_v) begin errors++; $display("FAIL spacing_status cyc=%0d got=%b required=%b", cyc, got_v, exp_v); end
         if (e_we) begin
            checks++;
            if (bus.RAM_WAddr !== e_addr || bus.RAM_D !== e_d) begin
               errors++; $display("FAIL spacing_write cyc=%0d got=%h/%h required=%h/%h", cyc, bus.RAM_WAddr, bus.RAM_D, e_addr, e_d);
            end
         end
      end
      checks++;
      if (bus.Overrun !== 1'b1 || bus.Full !== 1'b1) begin
         errors++; $display("FAIL overrun_sticky got ovr=%b full=%b required 1/1", bus.Overrun, bus.Full);
      end
   endtask

   task automatic test_consumed_strobe();
      int wes = 0;
      bit se, cons;
      logic [BW-1:0] l, r, lb, rb;
      lb = BW'($urandom); rb = BW'($urandom);
      clear_obs();
      for (int c = 0; c < 6; c++) begin
         se = (c < 2); cons = (c == 0);
         l = (c == 0) ? ~lb : lb;
         r = (c == 0) ? ~rb : rb;
         tick(1'b0, 1'b1, se, l, r, cons);
         if (bus.RAM_WE === 1'b1) wes++;
         checks++;
         if (got_v !== exp_v) begin errors++; $display("FAIL consume_status cyc=%0d got=%b required=%b", cyc, got_v, exp_v); end
         if (e_we) begin
            checks++;
            if (bus.RAM_WAddr !== e_addr || bus.RAM_D !== e_d) begin
               errors++; $display("FAIL consume_write cyc=%0d got=%h/%h required=%h/%h", cyc, bus.RAM_WAddr, bus.RAM_D, e_addr, e_d);
            end
         end
      end
      checks++;
      if (wes != 2 || obs[0] !== lb || obs[NPAIR] !== rb) begin
         errors++; $display("FAIL consume_same_cycle got writes=%0d %h/%h required 2 %h/%h", wes, obs[0], obs[NPAIR], lb, rb);
      end
   endtask

   task automatic test_enable_drop();
      bit se, en, rst;
      logic [BW-1:0] l, r, lt, ln;
      lt = '0; ln = '0;
      for (int c = 0; c < 20; c++) begin
         rst = (c == 0);
         en  = !(c == 12 || c == 13);
         se  = (c == 2 || c == 5 || c == 8 || c == 11 || c == 15);
         l = BW'($urandom); r = BW'($urandom);
         if (c == 11) lt = l;
         if (c == 15) ln = l;
         tick(rst, en, se, l, r, 1'b0);
         if (c == 11) begin
            checks++;
            if (bus.RAM_WE !== 1'b1 || bus.RAM_WAddr !== 4'd3 || bus.RAM_D !== lt) begin
               errors++; $display("FAIL drop_left got we=%b %h/%h required 1 3/%h", bus.RAM_WE, bus.RAM_WAddr, bus.RAM_D, lt);
            end
         end
         if (c == 12) begin
            checks++;
            if (bus.RAM_WE !== 1'b0 || bus.Level !== 3'd0) begin
               errors++; $display("FAIL drop_right got we=%b lvl=%0d required 0/0", bus.RAM_WE, bus.Level);
            end
         end
         if (c == 15) begin
            checks++;
            if (bus.RAM_WE !== 1'b1 || bus.RAM_WAddr !== 4'd0 || bus.RAM_D !== ln) begin
               errors++; $display("FAIL reenable_addr got we=%b %h/%h required 1 0/%h", bus.RAM_WE, bus.RAM_WAddr, bus.RAM_D, ln);
            end
         end
         checks++;
         if (got_v !== exp_v) begin errors++; $display("FAIL drop_status cyc=%0d got=%b required=%b", cyc, got_v, exp_v); end
         if (e_we) begin
            checks++;
            if (bus.RAM_WAddr !== e_addr || bus.RAM_D !== e_d) begin
               errors++; $display("FAIL drop_write cyc=%0d got=%h/%h required=%h/%h", cyc, bus.RAM_WAddr, bus.RAM_D, e_addr, e_d);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      bit se, rst;
      for (int c = 0; c < 10; c++) begin
         rst = (c == 0 || c == 6);
         se  = (c == 2 || c == 3 || c == 5);
         tick(rst, 1'b1, se, BW'($urandom), BW'($urandom), 1'b0);
         if (c == 4) begin
            checks++;
            if (bus.Overrun !== 1'b1) begin errors++; $display("FAIL pre_reset_overrun got=%b required=1", bus.Overrun); end
         end
         if (c == 6) begin
            checks++;
            if ({bus.RAM_WE, bus.RAM_WAddr, bus.RAM_D, bus.StartLoader, bus.Full, bus.Overrun, bus.Level} !== '0) begin
               errors++;
               $display("FAIL reset_mid got we=%b addr=%h d=%h st=%b full=%b ovr=%b lvl=%0d required all 0",
                        bus.RAM_WE, bus.RAM_WAddr, bus.RAM_D, bus.StartLoader, bus.Full, bus.Overrun, bus.Level);
            end
         end
         if (c == 7) begin
            checks++;
            if (bus.RAM_WE !== 1'b0) begin errors++; $display("FAIL reset_no_write got=%b required=0", bus.RAM_WE); end
         end
      end
   endtask

   task automatic test_random();
      bit se, en, cons;
      for (int c = 0; c < 900; c++) begin
         en   = (c == 0) || ($urandom_range(0, 99) != 0);
         se   = ($urandom_range(0, 2) == 0);
         cons = ($urandom_range(0, 5) == 0);
         tick(c == 0, en, se, BW'($urandom), BW'($urandom), cons);
         checks++;
         if (got_v !== exp_v) begin errors++; $display("FAIL random_status cyc=%0d got=%b required=%b", cyc, got_v, exp_v); end
         if (e_we) begin
            checks++;
            if (bus.RAM_WAddr !== e_addr || bus.RAM_D !== e_d) begin
               errors++; $display("FAIL random_write cyc=%0d got=%h/%h required=%h/%h", cyc, bus.RAM_WAddr, bus.RAM_D, e_addr, e_d);
            end
         end
      end
   endtask

   initial begin
      bus.Enable = 1'b0; bus.SampleEn = 1'b0; bus.Consumed = 1'b0;
      bus.DataL = '0; bus.DataR = '0;
      test_reset();
      test_fill_frame();
      test_full_hold();
      test_spacing();
      test_consumed_strobe();
      test_enable_drop();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout cyc=%0d required completion", cyc);
      $fatal(1, "timeout");
   end

endmodule
